upe_tripleadd_seq: RTL and testbench
====================================

# upe_tripleadd_seq

Sequencer for the 64-bit triple-operand adder (`upe_tripleadd64`). It latches three operands on a start request and drives them onto the adder. After a fixed settle window it captures the sum and carry-outs, then serialises the 64-bit result LSB-first onto a single LED pin at a programmable bit period. It sits between the board-level top (oscillator, LEDs) and the combinational adder, and replaces ad-hoc counter/bit-index logic in each top.

## Interface
Parameters:
- `WIDTH`, 64, operand/result width; bit index counter is `$clog2(WIDTH+1)` bits.
- `SETTLE`, 2, cycles (≥1) between driving operands and capturing `add_out`.
- `INTERVAL_W`, 32, width of the bit-period control.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted only in IDLE.
- `op_a`, `op_b`, `op_c` in WIDTH: operands, sampled on the accepted `start`.
- `interval` in INTERVAL_W: bit period is `interval+1` cycles; sampled on the accepted `start`.
- `add_a`, `add_b`, `add_c` out WIDTH: registered operands to the adder's `A`/`B`/`C`.
- `add_out` in WIDTH: adder `Out`.
- `add_co1`, `add_co2` in 1: adder `carryout1`/`carryout2`.
- `result` out WIDTH: captured sum.
- `carry` out 2: captured `{add_co2, add_co1}`.
- `led` out 1: serial bit output.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of serialisation.

## Operation
- States: IDLE, SETTLE, CAPTURE, SHIFT, DONE.
- IDLE:
  - `start=1` latches the operands into `add_a/b/c` and `interval` into `ival_q`.
  - Loads `settle_cnt=SETTLE-1`, then moves to SETTLE.
- SETTLE: decrements `settle_cnt`; moves to CAPTURE when it reaches 0.
- CAPTURE:
  - `result<=add_out` and `carry<={add_co2,add_co1}`.
  - `bitnum<=0`, `tick<=0`, then moves to SHIFT.
- SHIFT:
  - `led = result[bitnum]`, registered and valid from the first SHIFT cycle.
  - `tick` counts 0..`ival_q`. When `tick==ival_q`: `tick<=0`, `bitnum<=bitnum+1`.
  - After the last bit's period completes, moves to DONE.
- DONE: `led<=0`, `done=1` for one cycle, then IDLE.
- `add_a/b/c`, `result` and `carry` hold their values after DONE until the next accepted `start`.
- `start` while `busy` is ignored; requests are not queued.
- `interval` changes after acceptance have no effect on the current run.
- `interval=0` gives one cycle per bit. `interval` all-ones is legal, with no overflow because `tick` is INTERVAL_W wide.
- Reset, including mid-operation:
  - State goes to IDLE.
  - `add_a/b/c`, `result`, `carry`, `led`, `busy`, `done`, `bitnum`, `tick` all go to 0.

## Timing
- Cycle 0: `start` sampled. Cycle 1: `add_*` valid, state SETTLE.
- Capture at the edge ending cycle `SETTLE+1`. First SHIFT cycle is `SETTLE+2`.
- Bit k is held on `led` for cycles `SETTLE+2+k*(interval+1)` through `SETTLE+2+(k+1)*(interval+1)-1`.
- `done` is high in cycle `SETTLE+2+NB*(interval+1)`, where NB=WIDTH (WIDTH+1 with parity).
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- The earliest next `start` is accepted the cycle after `done`.

## Configuration
- `UPE_SEQ_PARITY_EN` defined:
  - Adds one extra SHIFT bit after bit WIDTH-1, so NB=WIDTH+1.
  - The extra bit is `^result` (even parity over the sum) and is held for `interval+1` cycles.
- `UPE_SEQ_PARITY_EN` undefined: NB=WIDTH, and no parity logic is synthesised.

## Test plan
- Smoke vector, default params, `interval=3`:
  - Stimulus: `op_a=5CD5153134D51531`, `op_b=EEEEEEEEEEEEEEEE`, `op_c=1111111111111112`.
  - `result=5CD5153134D51531`.
  - `led` sequence starts 1,0,0,0,1,1,0,0 (LSB-first), each bit held 4 cycles.
  - `done` pulses at cycle 4+64*4=260 after `start`.
  - `carry` matches the adder model.
- All-ones, `interval=0`:
  - Stimulus: operands FFFF…, FFFF…, 0000…0002.
  - `result=0000000000000000`, so `led` stays 0 for 64 cycles.
  - `done` is at cycle 68.
- Busy rejection: pulse `start` with new operands at cycle 10 of a run -> `add_*` and `result` unchanged; exactly one `done`.
- Reset mid-SHIFT: assert `rst_n=0` at bit 20 -> all outputs 0 immediately (async); after release, `busy=0` and a new `start` runs cleanly.
- Interval latch: change `interval` from 3 to 7 during SHIFT -> bit period stays at 4 cycles.
- With `UPE_SEQ_PARITY_EN` and smoke vector, `interval=1`:
  - 65th bit = XOR of all `result` bits.
  - `done` is at cycle 4+65*2=134.

Source files
------------

// File: rtl/upe_tripleadd_seq.sv
// rtl/upe_tripleadd_seq.sv - operand latch, settle/capture and LSB-first LED serialiser for upe_tripleadd64
// Optional: UPE_SEQ_PARITY_EN appends an even-parity bit after the result bits.
module upe_tripleadd_seq #(
  parameter int WIDTH      = 64,
  parameter int SETTLE     = 2,
  parameter int INTERVAL_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [WIDTH-1:0]      op_c,
  input  logic [INTERVAL_W-1:0] interval,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic [WIDTH-1:0]      add_c,
  input  logic [WIDTH-1:0]      add_out,
  input  logic                  add_co1,
  input  logic                  add_co2,
  output logic [WIDTH-1:0]      result,
  output logic [1:0]            carry,
  output logic                  led,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
`ifdef UPE_SEQ_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam logic [BW-1:0] LAST_BIT   = BW'(NB - 1);
  localparam logic [SW-1:0] SETTLE_LD  = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      add_a_q, add_a_d;
  logic [WIDTH-1:0]      add_b_q, add_b_d;
  logic [WIDTH-1:0]      add_c_q, add_c_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [1:0]            carry_q, carry_d;
  logic                  led_q, led_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [INTERVAL_W-1:0] ival_q, ival_d;
  logic [INTERVAL_W-1:0] tick_q, tick_d;
  logic [BW-1:0]         bitnum_q, bitnum_d;
  logic [SW-1:0]         settle_cnt_q, settle_cnt_d;

  logic [BW-1:0]         bitnum_inc;
  logic [WIDTH-1:0]      result_shifted;
  logic                  next_bit;

  // Bit that goes on the LED once the current bit period expires.
  always_comb begin
    bitnum_inc     = bitnum_q + BW'(1);
    result_shifted = result_q >> bitnum_inc;
    next_bit       = result_shifted[0];
`ifdef UPE_SEQ_PARITY_EN
    if (bitnum_inc == BW'(WIDTH)) next_bit = ^result_q;
`endif
  end

  always_comb begin
    state_d      = state_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_c_d      = add_c_q;
    result_d     = result_q;
    carry_d      = carry_q;
    led_d        = led_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ival_d       = ival_q;
    tick_d       = tick_q;
    bitnum_d     = bitnum_q;
    settle_cnt_d = settle_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          add_a_d      = op_a;
          add_b_d      = op_b;
          add_c_d      = op_c;
          ival_d       = interval;
          settle_cnt_d = SETTLE_LD;
          busy_d       = 1'b1;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          settle_cnt_d = settle_cnt_q - SW'(1);
        end
      end
      S_CAPTURE: begin
        result_d = add_out;
        carry_d  = {add_co2, add_co1};
        led_d    = add_out[0];
        bitnum_d = '0;
        tick_d   = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        if (tick_q == ival_q) begin
          tick_d = '0;
          if (bitnum_q == LAST_BIT) begin
            led_d   = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            bitnum_d = bitnum_inc;
            led_d    = next_bit;
          end
        end else begin
          tick_d = tick_q + INTERVAL_W'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_c_q      <= '0;
      result_q     <= '0;
      carry_q      <= '0;
      led_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ival_q       <= '0;
      tick_q       <= '0;
      bitnum_q     <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_c_q      <= add_c_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      led_q        <= led_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ival_q       <= ival_d;
      tick_q       <= tick_d;
      bitnum_q     <= bitnum_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign add_a  = add_a_q;
  assign add_b  = add_b_q;
  assign add_c  = add_c_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign led    = led_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_upe_tripleadd_seq.sv
// tb/tb_upe_tripleadd_seq.sv - directed bench for upe_tripleadd_seq with a behavioural triple adder
module tb_upe_tripleadd_seq;

  localparam int SETTLE = 2;
`ifdef UPE_SEQ_PARITY_EN
  localparam int NB = 65;
`else
  localparam int NB = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] op_a = '0, op_b = '0, op_c = '0;
  logic [31:0] interval = '0;
  logic [63:0] add_a, add_b, add_c, add_out, result;
  logic        add_co1, add_co2, led, busy, done;
  logic [1:0]  carry;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Adder model: carryout1 from A+B, carryout2 from (A+B)+C.
  logic [64:0] s1, s2;
  assign s1      = {1'b0, add_a} + {1'b0, add_b};
  assign s2      = {1'b0, s1[63:0]} + {1'b0, add_c};
  assign add_out = s2[63:0];
  assign add_co1 = s1[64];
  assign add_co2 = s2[64];

  upe_tripleadd_seq #(.WIDTH(64), .SETTLE(SETTLE), .INTERVAL_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .interval(interval),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .add_out(add_out), .add_co1(add_co1), .add_co2(add_co2),
    .result(result), .carry(carry), .led(led), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full run; optionally pokes start (with new operands) or interval at poke_cyc.
  task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                     input int iv, input logic [63:0] exp_res, input logic [1:0] exp_cy,
                     input int poke_cyc, input bit poke_start, input int iv_poke);
    int dcyc;
    int k;
    logic exp_led;
    dcyc = SETTLE + 2 + NB * (iv + 1);
    @(negedge clk);
    op_a = a; op_b = b; op_c = c; interval = iv; start = 1'b1;
    for (int n = 1; n <= dcyc; n++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("busy@%0d", n), 64'(busy), 64'(1));
      chk($sformatf("done@%0d", n), 64'(done), 64'(n == dcyc));
      if (n >= SETTLE + 2 && n < dcyc) begin
        k = (n - SETTLE - 2) / (iv + 1);
        exp_led = (k < 64) ? exp_res[k] : ^exp_res;
        chk($sformatf("led bit%0d @%0d", k, n), 64'(led), 64'(exp_led));
      end
      if (n == dcyc) chk("led_done", 64'(led), 64'(0));
      if (n == poke_cyc) begin
        interval = iv_poke;
        if (poke_start) begin
          start = 1'b1; op_a = ~a; op_b = ~b; op_c = ~c;
        end
      end
    end
    chk("result", result, exp_res);
    chk("carry", 64'(carry), 64'(exp_cy));
    chk("add_a", add_a, a);
    chk("add_b", add_b, b);
    chk("add_c", add_c, c);
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'(0));
    chk("done_after", 64'(done), 64'(0));
    chk("result_held", result, exp_res);
  endtask

  localparam logic [63:0] SA = 64'h5CD5153134D51531;
  localparam logic [63:0] SB = 64'hEEEEEEEEEEEEEEEE;
  localparam logic [63:0] SC = 64'h1111111111111112;
  localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] TWO  = 64'h0000000000000002;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", result, 64'h0);
    chk("rst_add_a", add_a, 64'h0);
    chk("rst_led", 64'(led), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_carry", 64'(carry), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

`ifdef UPE_SEQ_PARITY_EN
    run(SA, SB, SC, 1, SA, 2'b01, 0, 1'b0, 1);
`else
    // Smoke: sum wraps back to op_a; A+B carries, second add does not.
    run(SA, SB, SC, 3, SA, 2'b01, 0, 1'b0, 3);
    // All-ones + 2: zero result, both carries set.
    run(ONES, ONES, TWO, 0, 64'h0, 2'b11, 0, 1'b0, 0);
    // Start during a run is ignored.
    run(ONES, ONES, TWO, 0, 64'h0, 2'b11, 10, 1'b1, 0);
    // Interval change during SHIFT has no effect.
    run(SA, SB, SC, 3, SA, 2'b01, 20, 1'b0, 7);
`endif
    interval = 3;

    // Reset in the middle of bit 20 (cycles 84..87 at interval 3).
    @(negedge clk);
    op_a = SA; op_b = SB; op_c = SC; interval = 3; start = 1'b1;
    for (int n = 1; n <= 85; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("led_bit20", 64'(led), 64'(SA[20]));
    chk("busy_pre_rst", 64'(busy), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_led", 64'(led), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_result", result, 64'h0);
    chk("mid_rst_add_a", add_a, 64'h0);
    chk("mid_rst_add_c", add_c, 64'h0);
    chk("mid_rst_carry", 64'(carry), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'(0));
    run(ONES, ONES, TWO, 0, 64'h0, 2'b11, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
